// File: rtl/core_types_pkg.sv
// Shared core-wide sizing for the physical register file. PRF banks are
// selected by the low bits of the physical register number.
package core_types_pkg;
  localparam int PR_COUNT           = 64;
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT);
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT);
endpackage

// File: rtl/prf_read_arbiter_rr.sv
// rr_arbiter: N-way round-robin selector for one PRF bank. The search starts
// at the internal pointer and wraps. The pointer moves past the winner, and
// holds when there is no grant or the bank is disabled.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int LOGN = $clog2(N)
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         en_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);
  localparam int              PW   = (LOGN > 0) ? LOGN : 1;
  localparam logic [PW:0]     NV   = (PW+1)'(N);
  localparam logic [PW-1:0]   LAST = PW'(N-1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // First requester at or after the pointer wins; the pointer steps past it.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        sum = {1'b0, ptr_q} + (PW+1)'(k);
        if (sum >= NV) sum = sum - NV;
        idx = sum[PW-1:0];
        if (!found && req_i[idx]) begin
          found      = 1'b1;
          gnt_o[idx] = 1'b1;
          ptr_d      = (idx == LAST) ? '0 : idx + PW'(1);
        end
      end
    end
  end

  // Pointer register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/prf_read_arbiter.sv
// prf_read_arbiter: routes operand-collector reads onto banked PRF read ports.
// Grants are zero-latency. Each bank has its own round-robin arbiter. Read data
// comes back one cycle after the grant and is steered to the granted requestor.
// Optional feature: PRF_READ_ARB_CONFLICT_CNT_EN adds per-bank saturating
// conflict counters (conflict_count_by_bank).
module prf_read_arbiter
  import core_types_pkg::*;
#(
  parameter int REQUESTOR_COUNT     = 4,
  parameter int LOG_REQUESTOR_COUNT = $clog2(REQUESTOR_COUNT)
) (
  input  logic                                             CLK,
  input  logic                                             nRST,
  input  logic [REQUESTOR_COUNT-1:0]                       req_valid_by_rq,
  input  logic [REQUESTOR_COUNT-1:0][LOG_PR_COUNT-1:0]     req_pr_by_rq,
  output logic [REQUESTOR_COUNT-1:0]                       req_ack_by_rq,
  input  logic [PRF_BANK_COUNT-1:0]                        prf_bank_blocked_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                        prf_req_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]      prf_req_pr_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][31:0]                  prf_resp_data_by_bank,
  output logic [REQUESTOR_COUNT-1:0]                       resp_valid_by_rq,
  output logic [REQUESTOR_COUNT-1:0][31:0]                 resp_data_by_rq
`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
  ,
  output logic [PRF_BANK_COUNT-1:0][15:0]                  conflict_count_by_bank
`endif
);
  localparam int LB = LOG_PRF_BANK_COUNT;

  logic [PRF_BANK_COUNT-1:0][REQUESTOR_COUNT-1:0] bank_req;
  logic [PRF_BANK_COUNT-1:0][REQUESTOR_COUNT-1:0] bank_gnt;
  logic [REQUESTOR_COUNT-1:0]                     resp_vld_q, resp_vld_d;
  logic [REQUESTOR_COUNT-1:0][LB-1:0]             resp_bank_q, resp_bank_d;

  // Sort requests by target bank (low PR bits).
  always_comb begin
    bank_req = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++)
      for (int r = 0; r < REQUESTOR_COUNT; r++)
        bank_req[b][r] = req_valid_by_rq[r] &&
                         (req_pr_by_rq[r][LB-1:0] == LB'(b));
  end

  for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
    rr_arbiter #(
      .N    (REQUESTOR_COUNT),
      .LOGN (LOG_REQUESTOR_COUNT)
    ) u_rr (
      .CLK   (CLK),
      .nRST  (nRST),
      .en_i  (!prf_bank_blocked_by_bank[b]),
      .req_i (bank_req[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  // Fold per-bank grants into acks and bank issue; a requestor targets one bank,
  // so at most one bank grants it.
  always_comb begin
    req_ack_by_rq         = '0;
    prf_req_valid_by_bank = '0;
    prf_req_pr_by_bank    = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      prf_req_valid_by_bank[b] = |bank_gnt[b];
      for (int r = 0; r < REQUESTOR_COUNT; r++) begin
        req_ack_by_rq[r] = req_ack_by_rq[r] | bank_gnt[b][r];
        if (bank_gnt[b][r]) prf_req_pr_by_bank[b] = prf_req_pr_by_bank[b] | req_pr_by_rq[r];
      end
    end
  end

  // Remember which requestors were granted and from which bank.
  always_comb begin
    resp_vld_d  = req_ack_by_rq;
    resp_bank_d = '0;
    for (int r = 0; r < REQUESTOR_COUNT; r++)
      resp_bank_d[r] = req_pr_by_rq[r][LB-1:0];
  end

  // Grant tracking registers; reset drops any response still in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      resp_vld_q  <= '0;
      resp_bank_q <= '0;
    end else begin
      resp_vld_q  <= resp_vld_d;
      resp_bank_q <= resp_bank_d;
    end
  end

  // Steer bank data (arriving the cycle after issue) to the granted requestor.
  always_comb begin
    resp_valid_by_rq = resp_vld_q;
    resp_data_by_rq  = '0;
    for (int r = 0; r < REQUESTOR_COUNT; r++)
      if (resp_vld_q[r]) resp_data_by_rq[r] = prf_resp_data_by_bank[resp_bank_q[r]];
  end

`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
  logic [PRF_BANK_COUNT-1:0] conflict_hit;

  // A conflict is two or more requesters on one bank, or any request to a blocked bank.
  always_comb begin
    conflict_hit = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++)
      conflict_hit[b] = (|(bank_req[b] & (bank_req[b] - REQUESTOR_COUNT'(1)))) ||
                        (prf_bank_blocked_by_bank[b] && (|bank_req[b]));
  end

  // Saturating per-bank conflict counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) conflict_count_by_bank <= '0;
    else
      for (int b = 0; b < PRF_BANK_COUNT; b++)
        if (conflict_hit[b] && (conflict_count_by_bank[b] != 16'hFFFF))
          conflict_count_by_bank[b] <= conflict_count_by_bank[b] + 16'd1;
  end
`endif
endmodule

// File: tb/tb_prf_read_arbiter.sv
// Directed bench for prf_read_arbiter (4 banks, 4 requestors). Expected
// responses are queued per requestor at grant time; a negedge monitor pops
// and compares them whenever resp_valid is seen.
module tb_prf_read_arbiter;
  logic             CLK = 1'b0;
  logic             nRST;
  logic [3:0]       vld;
  logic [3:0][5:0]  pr;
  logic [3:0]       ack;
  logic [3:0]       blk;
  logic [3:0]       pvld;
  logic [3:0][5:0]  ppr;
  logic [3:0][31:0] bdata;
  logic [3:0]       rvld;
  logic [3:0][31:0] rdata;
`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
  logic [3:0][15:0] ccnt;
`endif

  int total = 0;
  int passed = 0;
  logic [31:0] exp_q[4][$];

  prf_read_arbiter #(.REQUESTOR_COUNT(4)) dut (
    .CLK                      (CLK),
    .nRST                     (nRST),
    .req_valid_by_rq          (vld),
    .req_pr_by_rq             (pr),
    .req_ack_by_rq            (ack),
    .prf_bank_blocked_by_bank (blk),
    .prf_req_valid_by_bank    (pvld),
    .prf_req_pr_by_bank       (ppr),
    .prf_resp_data_by_bank    (bdata),
    .resp_valid_by_rq         (rvld),
    .resp_data_by_rq          (rdata)
`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
    ,
    .conflict_count_by_bank   (ccnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every observed response must match the oldest expectation for that requestor.
  always @(negedge CLK) begin
    for (int r = 0; r < 4; r++) begin
      if (rvld[r]) begin
        if (exp_q[r].size() == 0) begin
          total++;
          $display("FAIL resp_unexpected rq%0d: got %h expected none", r, rdata[r]);
        end else begin
          check($sformatf("resp_data_rq%0d", r), rdata[r], exp_q[r].pop_front());
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; vld = '0; pr = '0; blk = '0; bdata = '0;
    #2;
    check("rst_resp_valid", 32'(rvld), 0);
    check("rst_resp_data0", rdata[0], 0);
    // Combinational path works in reset with pointers at 0
    vld = 4'b0001; pr[0] = 6'd5; #1;
    check("rst_ack", 32'(ack), 1);
    check("rst_bank_vld", 32'(pvld), 2);
    vld = 4'b1111; pr[0] = 6'd2; pr[1] = 6'd6; pr[2] = 6'd10; pr[3] = 6'd14; #1;
    check("rst_ptr0_ack", 32'(ack), 1);
    vld = '0; pr = '0;
    repeat (2) nxt();
    nRST = 1'b1;

    // Single read, bank1
    nxt(); vld = 4'b0001; pr[0] = 6'd5; #1;
    check("t1_ack", 32'(ack), 1);
    check("t1_bank_vld", 32'(pvld), 2);
    check("t1_bank_pr", 32'(ppr[1]), 5);
    exp_q[0].push_back(32'hDEADBEEF);
    nxt(); vld = '0; bdata[1] = 32'hDEADBEEF;

    // Four requestors contend on bank2
    pr[0] = 6'd2; pr[1] = 6'd6; pr[2] = 6'd10; pr[3] = 6'd14;
    for (int k = 0; k < 5; k++) begin
      nxt(); vld = 4'hF; bdata[2] = 32'h2000_0000 + 32'(k); #1;
      check($sformatf("t2_ack_c%0d", k), 32'(ack), 32'(1) << (k % 4));
      check($sformatf("t2_bank_vld_c%0d", k), 32'(pvld), 4);
      check($sformatf("t2_bank_pr_c%0d", k), 32'(ppr[2]), 32'(pr[k % 4]));
      exp_q[k % 4].push_back(32'h2000_0001 + 32'(k));
    end
    nxt(); vld = '0; bdata[2] = 32'h2000_0005;

    // Different banks in parallel
    nxt(); vld = 4'b0011; pr[0] = 6'd4; pr[1] = 6'd9; #1;
    check("t3_ack", 32'(ack), 3);
    check("t3_bank_vld", 32'(pvld), 3);
    check("t3_pr_b0", 32'(ppr[0]), 4);
    check("t3_pr_b1", 32'(ppr[1]), 9);
    exp_q[0].push_back(32'h0000_4444);
    exp_q[1].push_back(32'h1111_9999);
    nxt(); vld = '0; bdata[0] = 32'h0000_4444; bdata[1] = 32'h1111_9999;

    // Bank3 blocked two cycles; bank1 proceeds meanwhile
    for (int k = 0; k < 2; k++) begin
      nxt(); vld = 4'b0110; pr[1] = 6'd1; pr[2] = 6'd7; blk = 4'b1000;
      bdata[1] = 32'h3000_0000 + 32'(k); #1;
      check($sformatf("t4_blk_ack_c%0d", k), 32'(ack), 2);
      check($sformatf("t4_blk_bank_vld_c%0d", k), 32'(pvld), 2);
      exp_q[1].push_back(32'h3000_0001 + 32'(k));
    end
    nxt(); blk = '0; vld = 4'b0100; bdata[1] = 32'h3000_0002; #1;
    check("t4_unblk_ack", 32'(ack), 4);
    check("t4_unblk_bank_vld", 32'(pvld), 8);
    check("t4_unblk_pr", 32'(ppr[3]), 7);
    exp_q[2].push_back(32'h4000_0000);
    // Pointer is now 3: rq3 beats rq2, then wrap back to rq2
    nxt(); vld = 4'b1100; pr[3] = 6'd3; bdata[3] = 32'h4000_0000; #1;
    check("t4_ptr3_ack", 32'(ack), 8);
    check("t4_ptr3_pr", 32'(ppr[3]), 3);
    exp_q[3].push_back(32'h4000_0001);
    nxt(); bdata[3] = 32'h4000_0001; #1;
    check("t4_wrap_ack", 32'(ack), 4);
    check("t4_wrap_pr", 32'(ppr[3]), 7);
    exp_q[2].push_back(32'h4000_0002);
    nxt(); vld = '0; bdata[3] = 32'h4000_0002;

    // Three contended cycles on bank0 (pointer at 1): rq1, rq0, rq1
    pr[0] = 6'd0; pr[1] = 6'd4;
    for (int k = 0; k < 3; k++) begin
      nxt(); vld = 4'b0011; bdata[0] = 32'h5000_0000 + 32'(k); #1;
      check($sformatf("t5_ack_c%0d", k), 32'(ack), (k % 2 == 0) ? 2 : 1);
      exp_q[(k % 2 == 0) ? 1 : 0].push_back(32'h5000_0001 + 32'(k));
    end
    nxt(); vld = '0; bdata[0] = 32'h5000_0003;
`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
    check("cnt_bank0", 32'(ccnt[0]), 3);
    check("cnt_bank2", 32'(ccnt[2]), 5);
    check("cnt_bank3", 32'(ccnt[3]), 4);
`endif

    // Grant, then reset before the response cycle: no response must appear
    nxt(); vld = 4'b0001; pr[0] = 6'd8; #1;
    check("t6_ack", 32'(ack), 1);
    #1; nRST = 1'b0;
    #1; vld = '0;
    nxt();
    check("t6_resp_valid", 32'(rvld), 0);
    check("t6_resp_data0", rdata[0], 0);
`ifdef PRF_READ_ARB_CONFLICT_CNT_EN
    check("cnt_reset_b0", 32'(ccnt[0]), 0);
    check("cnt_reset_b2", 32'(ccnt[2]), 0);
`endif
    nxt(); nRST = 1'b1;

    // Bank2 pointer was 1 before reset; it must restart at 0
    nxt(); vld = 4'hF; pr[0] = 6'd2; pr[1] = 6'd6; pr[2] = 6'd10; pr[3] = 6'd14; #1;
    check("t7_ptr_reset_ack", 32'(ack), 1);
    exp_q[0].push_back(32'h6000_0000);
    nxt(); vld = '0; bdata[2] = 32'h6000_0000;
    repeat (2) nxt();
    for (int r = 0; r < 4; r++)
      check($sformatf("drain_rq%0d", r), 32'(exp_q[r].size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/prf_read_arbiter.md
PRF_READ_ARBITER -- requirements
Module: prf_read_arbiter

Interface
REQ-001 SHALL take parameter REQUESTOR_COUNT, default 4: number of operand collectors sharing the PRF read ports.
REQ-002 SHALL take parameter LOG_REQUESTOR_COUNT, default $clog2(REQUESTOR_COUNT): requestor index width.
REQ-003 SHALL have port CLK  in  1  single clock, all state on posedge.
REQ-004 SHALL have port nRST  in  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_by_rq  in  [REQUESTOR_COUNT]  read request per requestor.
REQ-006 SHALL have port req_pr_by_rq  in  [REQUESTOR_COUNT][LOG_PR_COUNT]  physical register to read.
REQ-007 SHALL have port req_ack_by_rq  out  [REQUESTOR_COUNT]  same-cycle grant.
REQ-008 SHALL have port prf_bank_blocked_by_bank  in  [PRF_BANK_COUNT]  bank read port unavailable this cycle.
REQ-009 SHALL have port prf_req_valid_by_bank  out  [PRF_BANK_COUNT]  bank read issued.
REQ-010 SHALL have port prf_req_pr_by_bank  out  [PRF_BANK_COUNT][LOG_PR_COUNT]  PR sent to bank.
REQ-011 SHALL have port prf_resp_data_by_bank  in  [PRF_BANK_COUNT][32]  bank read data, one cycle after issue.
REQ-012 SHALL have port resp_valid_by_rq  out  [REQUESTOR_COUNT]  read data return.
REQ-013 SHALL have port resp_data_by_rq  out  [REQUESTOR_COUNT][32]  returned data.

Function
REQ-014 SHALL map a request to bank req_pr[LOG_PRF_BANK_COUNT-1:0].
REQ-015 SHALL grant at most one requestor per bank per cycle; requests to different banks SHALL be granted in the same cycle.
REQ-016 SHALL arbitrate per bank round-robin: search from that bank's pointer upward, wrapping at REQUESTOR_COUNT-1 to 0.
REQ-017 After a grant to requestor i, the bank pointer SHALL become (i+1) mod REQUESTOR_COUNT; without a grant it SHALL hold.
REQ-018 A blocked bank SHALL issue nothing, ack nothing and hold its pointer.
REQ-019 req_ack and prf_req_valid/prf_req_pr SHALL be combinational in the request cycle (zero latency).
REQ-020 An unacked requestor SHALL hold valid and PR; the arbiter SHALL tolerate a PR change between cycles (no stickiness).
REQ-021 For a grant to requestor r on bank b in cycle t, resp_valid_by_rq[r] SHALL be 1 in t+1 with resp_data_by_rq[r] = prf_resp_data_by_bank[b] in t+1.
REQ-022 resp_valid SHALL be 0 in cycles not following a grant; resp_data is don't-care then (recommended 0).
REQ-023 Back-to-back grants to one requestor in t and t+1 SHALL return responses in t+1 and t+2 in order.

Reset
REQ-024 On nRST low: all bank pointers = 0, resp_valid_by_rq = 0, resp_data_by_rq = 0, registered grant state cleared.
REQ-025 Combinational outputs (req_ack, prf_req_*) SHALL follow inputs with pointers at 0 during reset.
REQ-026 A grant issued in the cycle reset asserts SHALL yield no response.

Configuration
REQ-027 With PRF_READ_ARB_CONFLICT_CNT_EN defined, SHALL add output conflict_count_by_bank [PRF_BANK_COUNT][16] that increments each cycle a bank has ≥2 requests or a blocked bank has ≥1 request, saturates at 16'hFFFF and resets to 0.
REQ-028 Without PRF_READ_ARB_CONFLICT_CNT_EN, the port and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-029 PRF_BANK_COUNT, LOG_PRF_BANK_COUNT and LOG_PR_COUNT SHALL come from core_types_pkg; no new package types.
REQ-030 Per-bank round-robin selection SHALL be a sub-module rr_arbiter (REQUESTOR_COUNT-wide request in, one-hot grant out, pointer internal), instantiated once per bank.

Verification (PRF_BANK_COUNT=4, REQUESTOR_COUNT=4)
REQ-031 After reset, rq0 requests PR 5 -> same cycle ack[0]=1 and prf_req_valid[1]=1 with PR 5; next cycle bank1 data 32'hDEADBEEF -> resp_valid[0]=1, resp_data[0]=32'hDEADBEEF.
REQ-032 rq0..3 all request bank 2 (PRs 2,6,10,14) continuously -> grant order 0,1,2,3,0 over 5 cycles, one ack per cycle.
REQ-033 rq0 PR 4 (bank0), rq1 PR 9 (bank1) in the same cycle -> both acked; responses to rq0 and rq1 carry the bank0 and bank1 data respectively next cycle.
REQ-034 Bank 3 blocked 2 cycles while rq2 requests PR 7 -> no ack for 2 cycles, ack in cycle 3, pointer unchanged until grant.
REQ-035 Grant in cycle t, nRST asserted in t+1 -> resp_valid stays 0; with the macro, 3 contended cycles on bank0 -> conflict_count[0]=3, then reset -> 0.
